// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ID/EX issue stage for the 32-bit RISC-V core. It decodes the instruction
// into an ALU operation code and operand selection, then holds the result in
// a single-entry pipeline register that feeds the ALU.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   id_valid / id_ready  handshake with the decode stage
//   id_instr             raw 32-bit instruction word
//   id_rs1_data/rs2_data register operands
//   id_imm               sign-extended immediate
//   flush                mispredict; kills the held entry and any arrival
//   ex_valid / ex_ready  handshake with the EX stage
//   ex_alu_op, ex_a/b    ALU operation and operands
//   ex_rd, ex_reg_we     destination register and write enable
//   ex_is_branch         instruction is BEQ
//   ex_illegal           instruction is unsupported (still flows through)
//   issued_cnt           wrapping count of entries consumed by EX
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_instr,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [4:0]       ex_alu_op,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_we,
    output logic             ex_is_branch,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    typedef enum logic {EMPTY, FULL} state_e;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_EQ  = 5'b00100;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE= 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    logic [4:0]      dec_op;
    logic            dec_b_imm;
    logic            dec_we;
    logic            dec_br;
    logic            dec_ill;
    logic [XLEN-1:0] dec_b;

    state_e          state_q, state_d;
    logic [4:0]      alu_op_q, alu_op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_we_q, reg_we_d;
    logic            is_branch_q, is_branch_d;
    logic            illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic capture;
    logic consume;

    // Register-source fields are carried by the rs*_data ports instead.
    logic unused_instr_bits;
    assign unused_instr_bits = ^id_instr[24:15];

    assign opcode = id_instr[6:0];
    assign f3     = id_instr[14:12];
    assign f7     = id_instr[31:25];

    // Instruction decode; anything not matched falls through as illegal.
    always_comb begin
        dec_op    = OP_ADD;
        dec_b_imm = 1'b0;
        dec_we    = 1'b0;
        dec_br    = 1'b0;
        dec_ill   = 1'b1;
        unique case (opcode)
            OPC_R: begin
                if (f3 == 3'b000 && f7 == 7'b0000000) begin
                    dec_op = OP_ADD; dec_we = 1'b1; dec_ill = 1'b0;
                end else if (f3 == 3'b000 && f7 == 7'b0100000) begin
                    dec_op = OP_SUB; dec_we = 1'b1; dec_ill = 1'b0;
                end else if (f3 == 3'b111 && f7 == 7'b0000000) begin
                    dec_op = OP_AND; dec_we = 1'b1; dec_ill = 1'b0;
                end else if (f3 == 3'b110 && f7 == 7'b0000000) begin
                    dec_op = OP_OR;  dec_we = 1'b1; dec_ill = 1'b0;
                end
            end
            OPC_I: begin
                if (f3 == 3'b000) begin
                    dec_op = OP_ADD; dec_b_imm = 1'b1; dec_we = 1'b1; dec_ill = 1'b0;
                end else if (f3 == 3'b111) begin
                    dec_op = OP_AND; dec_b_imm = 1'b1; dec_we = 1'b1; dec_ill = 1'b0;
                end else if (f3 == 3'b110) begin
                    dec_op = OP_OR;  dec_b_imm = 1'b1; dec_we = 1'b1; dec_ill = 1'b0;
                end
            end
            OPC_LOAD: begin
                if (f3 == 3'b010) begin
                    dec_op = OP_ADD; dec_b_imm = 1'b1; dec_we = 1'b1; dec_ill = 1'b0;
                end
            end
            OPC_STORE: begin
                if (f3 == 3'b010) begin
                    dec_op = OP_ADD; dec_b_imm = 1'b1; dec_ill = 1'b0;
                end
            end
            OPC_BR: begin
                if (f3 == 3'b000) begin
                    dec_op = OP_EQ; dec_br = 1'b1; dec_ill = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign dec_b = dec_b_imm ? id_imm : id_rs2_data;

    assign ex_valid = (state_q == FULL);
    assign id_ready = !ex_valid || ex_ready;
    assign capture  = id_valid && id_ready && !flush;
    assign consume  = ex_valid && ex_ready;

    // Next-state: flush wins, then capture, then drain. Data fields only
    // change on capture so a stalled entry stays stable.
    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        reg_we_d    = reg_we_q;
        is_branch_d = is_branch_q;
        illegal_d   = illegal_q;
        cnt_d       = cnt_q;

        if (consume) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (flush) begin
            state_d = EMPTY;
        end else if (capture) begin
            state_d     = FULL;
            alu_op_d    = dec_op;
            a_d         = id_rs1_data;
            b_d         = dec_b;
            rd_d        = id_instr[11:7];
            reg_we_d    = dec_we;
            is_branch_d = dec_br;
            illegal_d   = dec_ill;
        end else if (consume) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            alu_op_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            reg_we_q    <= 1'b0;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            reg_we_q    <= reg_we_d;
            is_branch_q <= is_branch_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_alu_op    = alu_op_q;
    assign ex_a         = a_q;
    assign ex_b         = b_q;
    assign ex_rd        = rd_q;
    assign ex_reg_we    = reg_we_q;
    assign ex_is_branch = is_branch_q;
    assign ex_illegal   = illegal_q;
    assign issued_cnt   = cnt_q;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue stage for the 32-bit RISC-V core. Decodes the instruction into the 5-bit ALU operation code and operand selection, then holds the result in a single-entry pipeline register. The register is the producer side of the ALU's `ALUOp`/`A`/`B` inputs. It uses a valid/ready handshake on both sides, and a flush from the branch-resolution logic discards any held or arriving instruction.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.
- `CNT_W`, 16: width of the issued-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode stage offers an instruction.
- `id_ready`  out  1  stage can accept an instruction this cycle.
- `id_instr`  in  32  raw instruction word.
- `id_rs1_data`  in  XLEN  rs1 register value.
- `id_rs2_data`  in  XLEN  rs2 register value.
- `id_imm`  in  XLEN  sign-extended immediate from the decoder.
- `flush`  in  1  mispredict; kill the held entry and any arriving instruction.
- `ex_valid`  out  1  EX register holds a live instruction.
- `ex_ready`  in  1  EX stage consumes the entry this cycle.
- `ex_alu_op`  out  5  ALU operation code.
- `ex_a`  out  XLEN  ALU operand A.
- `ex_b`  out  XLEN  ALU operand B.
- `ex_rd`  out  5  destination register, `instr[11:7]`.
- `ex_reg_we`  out  1  result is written to the register file.
- `ex_is_branch`  out  1  the instruction is BEQ.
- `ex_illegal`  out  1  the instruction is unsupported.
- `issued_cnt`  out  CNT_W  count of entries accepted by EX.

## Operation
ALU op codes:
- 00000 ADD
- 00001 SUB
- 00010 AND
- 00011 OR
- 00100 EQ

Decode, keyed on `opcode = instr[6:0]`, `f3 = instr[14:12]`, `f7 = instr[31:25]`:
- 0110011 (R-type), A=rs1, B=rs2, reg_we=1:
  - f3=000, f7=0000000 → ADD
  - f3=000, f7=0100000 → SUB
  - f3=111, f7=0 → AND
  - f3=110, f7=0 → OR
- 0010011 (I-type), A=rs1, B=imm, reg_we=1: f3=000 → ADD; f3=111 → AND; f3=110 → OR.
- 0000011 with f3=010 (LW): ADD, A=rs1, B=imm, reg_we=1.
- 0100011 with f3=010 (SW): ADD, A=rs1, B=imm, reg_we=0.
- 1100011 with f3=000 (BEQ): EQ, A=rs1, B=rs2, reg_we=0, is_branch=1.
- Any other encoding: illegal=1, alu_op=00000, A=rs1, B=rs2, reg_we=0, is_branch=0. The entry still flows through the stage so the exception logic can see it.
- `rd` = 0 with reg_we=1 is legal. Write suppression for x0 is the register file's job.

Pipeline register (single entry, two states):
- EMPTY: `ex_valid`=0.
- FULL: `ex_valid`=1.
- `id_ready = !ex_valid || ex_ready`. The ready path is combinational so the pipeline stays full-throughput.
- Capture when `id_valid && id_ready && !flush`: load decoded fields, set `ex_valid`=1.
- Consumed without a new capture: `ex_valid`=0.
- Hold when `ex_valid && !ex_ready`: all ex_* outputs stay stable. The stage must not change them while stalled.
- Flush has priority over everything:
  - next cycle `ex_valid`=0;
  - an instruction offered in the flush cycle is dropped, even though `id_ready` may be 1;
  - `issued_cnt` still increments if `ex_valid && ex_ready` in that same cycle.
- `issued_cnt` increments by 1 on every cycle with `ex_valid && ex_ready`. It wraps modulo 2^CNT_W. Illegal entries are counted.

## Timing
- Reset (asynchronous, `rst_n`=0): `ex_valid`=0, every ex_* data output is 0, `issued_cnt`=0.
- During reset `id_ready`=1 (it follows from `ex_valid`=0).
- Latency: an instruction accepted at edge N appears on ex_* immediately after edge N. One cycle from ID to EX.
- Throughput: one instruction per cycle while `ex_ready`=1.
- Back-to-back case: when FULL and `ex_ready`=1 with `id_valid`=1, the old entry is consumed and the new one is captured at the same edge. `ex_valid` stays 1.
- Reset asserted mid-stall: the entry is lost and the outputs go to their reset values at once, without waiting for a clock edge.
- No combinational path from `id_*` data inputs to ex_* outputs.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `ex_valid`=0, all ex_* outputs 0, `issued_cnt`=0, `id_ready`=1.
- SUB: rs1=5, rs2=3, `ex_ready`=1, offer SUB x3,x1,x2 (0x402081B3) → next cycle `ex_alu_op`=00001, `ex_a`=5, `ex_b`=3, `ex_rd`=3, `ex_reg_we`=1, `issued_cnt`=1.
- Stall: present ADDI x1,x0,-1 (imm 0xFFFFFFFF) with `ex_ready`=0 for 3 cycles → ex_* outputs constant at alu_op=00000, B=0xFFFFFFFF; `id_ready`=0; the entry drains on the first cycle with `ex_ready`=1.
- Flush: FULL with BEQ (`ex_is_branch`=1, alu_op=00100), then in one cycle assert `flush`=1 while offering OR (0x0020E1B3) → next cycle `ex_valid`=0 and the OR never appears.
- Illegal: offer 0x0000007F → `ex_illegal`=1, `ex_reg_we`=0, `ex_alu_op`=00000.
- Counter wrap: with CNT_W=4, issue 17 back-to-back ADDs with `ex_ready` held at 1 → `ex_valid` never drops; `issued_cnt` reads 1 after the 17th is consumed.
